// File: rtl/debounce_onepulse.sv
// Pushbutton front end: 2-flop synchroniser, tick-sampled shift-register
// debouncer, press/release pulses and long-press detection in clk_40M.
module debounce_onepulse #(
  parameter int N_PB       = 4,
  parameter int DEPTH      = 4,
  parameter int LONG_TICKS = 150,
  parameter int CNT_W      = 8
) (
  input  logic            clk_40M,
  input  logic            rst,
  input  logic            clk_debounce,
  input  logic [N_PB-1:0] pb_in,
  output logic [N_PB-1:0] pb_debounced,
  output logic [N_PB-1:0] pb_press,
  output logic [N_PB-1:0] pb_release,
  output logic [N_PB-1:0] pb_long,
  output logic [N_PB-1:0] pb_held
);

  localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_TICKS - 1);
  localparam logic [DEPTH-1:0] ONES    = '1;

  logic [N_PB-1:0]  sync1_q;
  logic [N_PB-1:0]  sync2_q;
  logic             dbc_q;
  logic             tick;

  logic [DEPTH-1:0] sh_q [N_PB];
  logic [DEPTH-1:0] sh_d [N_PB];
  logic [CNT_W-1:0] hc_q [N_PB];
  logic [CNT_W-1:0] hc_d [N_PB];

  logic [N_PB-1:0]  deb_q;
  logic [N_PB-1:0]  deb_d;
  logic [N_PB-1:0]  press_q;
  logic [N_PB-1:0]  press_d;
  logic [N_PB-1:0]  rel_q;
  logic [N_PB-1:0]  rel_d;
  logic [N_PB-1:0]  long_q;
  logic [N_PB-1:0]  long_d;
  logic [N_PB-1:0]  held_q;
  logic [N_PB-1:0]  held_d;

  // clk_debounce is a data level here; one tick per rising edge
  assign tick = clk_debounce & ~dbc_q;

  always_comb begin
    sh_d   = sh_q;
    hc_d   = hc_q;
    deb_d  = deb_q;
    long_d = '0;
    for (int i = 0; i < N_PB; i++) begin
      if (tick) begin
        sh_d[i] = {sh_q[i][DEPTH-2:0], sync2_q[i]};
      end
      unique case (1'b1)
        (sh_q[i] == ONES): deb_d[i] = 1'b1;
        (sh_q[i] == '0):   deb_d[i] = 1'b0;
        default:           deb_d[i] = deb_q[i];
      endcase
      // a falling level wins over a coincident saturation tick
      if (!deb_q[i] || !deb_d[i]) begin
        hc_d[i] = '0;
      end else if (tick && (hc_q[i] < LONG_C)) begin
        hc_d[i]   = hc_q[i] + CNT_W'(1);
        long_d[i] = (hc_q[i] == LONG_M1);
      end
    end
    press_d = deb_d & ~deb_q;
    rel_d   = ~deb_d & deb_q;
    held_d  = deb_d & (held_q | long_d);
  end

  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      dbc_q   <= 1'b0;
      deb_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
      held_q  <= '0;
      for (int i = 0; i < N_PB; i++) begin
        sh_q[i] <= '0;
        hc_q[i] <= '0;
      end
    end else begin
      sync1_q <= pb_in;
      sync2_q <= sync1_q;
      dbc_q   <= clk_debounce;
      deb_q   <= deb_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      held_q  <= held_d;
      for (int i = 0; i < N_PB; i++) begin
        sh_q[i] <= sh_d[i];
        hc_q[i] <= hc_d[i];
      end
    end
  end

  assign pb_debounced = deb_q;
  assign pb_press     = press_q;
  assign pb_release   = rel_q;
  assign pb_long      = long_q;
  assign pb_held      = held_q;

endmodule
